// File: rtl/a2d_pkg.sv
// +--------------------------------------------------------------------+
// | a2d_pkg : shared types, channel map and helpers for the A2D front   |
// | end (ld_cell_a2d_intf).                  Rev 1.0 - initial release  |
// +--------------------------------------------------------------------+
`default_nettype none

package a2d_pkg;

   typedef enum logic [2:0] {IDLE, CMD, GAP, READ, UPDATE} a2d_state_t;
   typedef enum logic [1:0] {RR_LFT, RR_RGHT, RR_STEER, RR_BATT} rr_ch_t;

   localparam int         DEF_SCLK_DIV_W = 5;
   localparam logic [2:0] DEF_CH_LFT     = 3'd0;
   localparam logic [2:0] DEF_CH_RGHT    = 3'd4;
   localparam logic [2:0] DEF_CH_STEER   = 3'd5;
   localparam logic [2:0] DEF_CH_BATT    = 3'd6;

   function automatic rr_ch_t rr_next(input rr_ch_t cur);
      case (cur)
         RR_LFT:   return RR_RGHT;
         RR_RGHT:  return RR_STEER;
         RR_STEER: return RR_BATT;
         default:  return RR_LFT;
      endcase
   endfunction

   function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
      return {2'b00, ch, 11'h000};
   endfunction

   // 13-bit sum keeps the carry so the truncated mean never wraps
   function automatic logic [11:0] avg12(input logic [11:0] a, input logic [11:0] b);
      logic [12:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[12:1];
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_mnrch.sv
// +--------------------------------------------------------------------+
// | spi_mnrch : 16-bit SPI master, SCLK idles high, MOSI changes on     |
// | SCLK fall, MISO sampled on SCLK rise.    Rev 1.0 - initial release  |
// +--------------------------------------------------------------------+
`default_nettype none

module spi_mnrch #(
   parameter int SCLK_DIV_W = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wrt,
   input  logic [15:0] wt_data,
   input  logic        MISO,
   output logic        done,
   output logic [15:0] rd_data,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI
);

   // Loading 2**W-8 places the first SCLK fall 8 clocks after SS_n drops
   localparam logic [SCLK_DIV_W-1:0] DIV_LOAD = SCLK_DIV_W'(2**SCLK_DIV_W - 8);
   localparam logic [SCLK_DIV_W-1:0] DIV_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
   localparam logic [SCLK_DIV_W-1:0] DIV_FALL = '1;

   logic [SCLK_DIV_W-1:0] div;
   logic [15:0]           shreg;
   logic [4:0]            rise_cnt;
   logic                  miso_smpl;
   logic                  active;
   logic                  end_pend;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active    <= 1'b0;
         SS_n      <= 1'b1;
         div       <= '0;
         shreg     <= '0;
         rise_cnt  <= '0;
         miso_smpl <= 1'b0;
         end_pend  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done     <= end_pend;
         end_pend <= 1'b0;
         if (wrt) begin
            active   <= 1'b1;
            SS_n     <= 1'b0;
            div      <= DIV_LOAD;
            shreg    <= wt_data;
            rise_cnt <= '0;
         end else if (active) begin
            div <= div + SCLK_DIV_W'(1);
            if (div == DIV_RISE) begin
               miso_smpl <= MISO;
               rise_cnt  <= rise_cnt + 5'd1;
            end
            // The 17th fall position never toggles SCLK: it closes the frame
            if (div == DIV_FALL) begin
               if (rise_cnt == 5'd16) begin
                  shreg    <= {shreg[14:0], miso_smpl};
                  active   <= 1'b0;
                  SS_n     <= 1'b1;
                  end_pend <= 1'b1;
               end else if (rise_cnt != 5'd0) begin
                  shreg <= {shreg[14:0], miso_smpl};
               end
            end
         end
      end
   end

   assign SCLK    = active ? div[SCLK_DIV_W-1] : 1'b1;
   assign MOSI    = active ? shreg[15] : 1'b0;
   assign rd_data = shreg;

endmodule

`default_nettype wire

// File: rtl/ld_cell_a2d_intf.sv
// +--------------------------------------------------------------------+
// | ld_cell_a2d_intf : round-robin A2D sequencer for load cells, steer  |
// | pot and battery. Option: `LD_AVG_EN.     Rev 1.0 - initial release  |
// +--------------------------------------------------------------------+
`default_nettype none

module ld_cell_a2d_intf
   import a2d_pkg::*;
#(
   parameter int         SCLK_DIV_W = DEF_SCLK_DIV_W,
   parameter logic [2:0] CH_LFT     = DEF_CH_LFT,
   parameter logic [2:0] CH_RGHT    = DEF_CH_RGHT,
   parameter logic [2:0] CH_STEER   = DEF_CH_STEER,
   parameter logic [2:0] CH_BATT    = DEF_CH_BATT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        nxt,
   input  logic        MISO,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   output logic [11:0] lft_ld,
   output logic [11:0] rght_ld,
   output logic [11:0] steer_pot,
   output logic [11:0] batt,
   output logic        cnv_cmplt
);

   a2d_state_t  state, state_nx;
   rr_ch_t      rr;
   logic [2:0]  ch;
   logic        wrt;
   logic        done;
   logic [15:0] rd_data;
   logic [11:0] sample;
   logic        unused_rd_hi;

   spi_mnrch #(.SCLK_DIV_W(SCLK_DIV_W)) u_spi (
      .clk     (clk),
      .rst_n   (rst_n),
      .wrt     (wrt),
      .wt_data (a2d_cmd(ch)),
      .MISO    (MISO),
      .done    (done),
      .rd_data (rd_data),
      .SS_n    (SS_n),
      .SCLK    (SCLK),
      .MOSI    (MOSI)
   );

   assign sample       = rd_data[11:0];
   assign unused_rd_hi = &{1'b0, rd_data[15:12]};

   always_comb begin
      ch = CH_LFT;
      case (rr)
         RR_RGHT:  ch = CH_RGHT;
         RR_STEER: ch = CH_STEER;
         RR_BATT:  ch = CH_BATT;
         default:  ch = CH_LFT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // The first frame only loads the channel address; its reply is discarded
   always_comb begin
      state_nx = state;
      wrt      = 1'b0;
      case (state)
         IDLE:   if (nxt) begin wrt = 1'b1; state_nx = CMD; end
         CMD:    if (done) state_nx = GAP;
         GAP:    begin wrt = 1'b1; state_nx = READ; end
         READ:   if (done) state_nx = UPDATE;
         UPDATE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign cnv_cmplt = (state == UPDATE);

`ifdef LD_AVG_EN
   logic [11:0] lft_prev, rght_prev;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lft_ld    <= '0;
         rght_ld   <= '0;
         steer_pot <= '0;
         batt      <= '0;
         rr        <= RR_LFT;
`ifdef LD_AVG_EN
         lft_prev  <= '0;
         rght_prev <= '0;
`endif
      end else begin
         if (state == READ && done) begin
            case (rr)
`ifdef LD_AVG_EN
               RR_LFT:   begin lft_ld  <= avg12(sample, lft_prev);  lft_prev  <= sample; end
               RR_RGHT:  begin rght_ld <= avg12(sample, rght_prev); rght_prev <= sample; end
`else
               RR_LFT:   lft_ld  <= sample;
               RR_RGHT:  rght_ld <= sample;
`endif
               RR_STEER: steer_pot <= sample;
               default:  batt      <= sample;
            endcase
         end
         if (state == UPDATE) rr <= rr_next(rr);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ld_cell_a2d_intf.sv
// +--------------------------------------------------------------------+
// | tb_ld_cell_a2d_intf : directed bench with an AD7927-style slave     |
// | model (reply = value of previously addressed channel). Rev 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_ld_cell_a2d_intf;

   localparam int LIMIT = 3000;

   logic        clk = 1'b0, rst_n = 1'b0, nxt = 1'b0, MISO = 1'b0;
   logic        SS_n, SCLK, MOSI, cnv_cmplt;
   logic [11:0] lft_ld, rght_ld, steer_pot, batt;

   int checks = 0, errors = 0, ref_lat = 0, cyc = 0;

   ld_cell_a2d_intf dut (
      .clk(clk), .rst_n(rst_n), .nxt(nxt), .MISO(MISO),
      .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
      .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot), .batt(batt),
      .cnv_cmplt(cnv_cmplt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // ---------------- A2D slave model and frame monitor ----------------
   logic [11:0] adc_val [8];
   logic [2:0]  adc_ch = 3'd0;
   logic [15:0] tx = '0, rx = '0;
   logic [15:0] cmd_q [$];
   logic        prev_ss = 1'b1, prev_sclk = 1'b1;
   int fall_cnt = 0, rise_cnt = 0, ss_fall_cyc = 0, ss_rise_cyc = 0;
   int last_fall_cyc = 0, last_rise_cyc = 0;
   int lead = 0, gap = 0, tail = 0, per_min = 0, per_max = 0, half_min = 0, half_max = 0;

   always @(negedge clk) begin
      if (prev_ss === 1'b1 && SS_n === 1'b0) begin
         gap = cyc - ss_rise_cyc;
         fall_cnt = 0; rise_cnt = 0; rx = '0;
         per_min = 9999; per_max = 0; half_min = 9999; half_max = 0;
         tx = {4'h0, adc_val[adc_ch]};
         MISO = tx[15];
         ss_fall_cyc = cyc;
      end else if (SS_n === 1'b0) begin
         if (prev_sclk === 1'b1 && SCLK === 1'b0) begin
            fall_cnt++;
            if (fall_cnt == 1) lead = cyc - ss_fall_cyc;
            else begin
               if (cyc - last_fall_cyc < per_min) per_min = cyc - last_fall_cyc;
               if (cyc - last_fall_cyc > per_max) per_max = cyc - last_fall_cyc;
               tx = {tx[14:0], 1'b0};
               MISO = tx[15];
            end
            last_fall_cyc = cyc;
         end
         if (prev_sclk === 1'b0 && SCLK === 1'b1) begin
            rise_cnt++;
            rx = {rx[14:0], MOSI};
            if (cyc - last_fall_cyc < half_min) half_min = cyc - last_fall_cyc;
            if (cyc - last_fall_cyc > half_max) half_max = cyc - last_fall_cyc;
            last_rise_cyc = cyc;
         end
      end else if (prev_ss === 1'b0 && SS_n === 1'b1) begin
         ss_rise_cyc = cyc;
         if (rise_cnt == 16) begin
            tail = cyc - last_rise_cyc;
            cmd_q.push_back(rx);
            adc_ch = rx[13:11];
         end
      end
      prev_ss = SS_n;
      prev_sclk = SCLK;
   end

   // ---------------- expected-value model ----------------
   logic [11:0] el = '0, er = '0, es = '0, eb = '0, pl = '0, pr = '0;
   int slot = 0;
   int chn [4] = '{0, 4, 5, 6};

   task automatic model_ld(input logic [11:0] raw, inout logic [11:0] prev, inout logic [11:0] res);
      logic [12:0] s;
      s = {1'b0, raw} + {1'b0, prev};
`ifdef LD_AVG_EN
      res = s[12:1];
`else
      res = raw;
`endif
      prev = raw;
   endtask

   task automatic model_conv();
      logic [11:0] raw;
      raw = adc_val[chn[slot]];
      case (slot)
         0: model_ld(raw, pl, el);
         1: model_ld(raw, pr, er);
         2: es = raw;
         default: eb = raw;
      endcase
      slot = (slot + 1) % 4;
   endtask

   task automatic model_reset();
      el = '0; er = '0; es = '0; eb = '0; pl = '0; pr = '0; slot = 0;
   endtask

   task automatic run_conv(input int inject_at, output int lat, output int pulses);
      lat = 0; pulses = 0;
      @(negedge clk); nxt = 1'b1;
      do begin
         @(negedge clk); lat++;
         nxt = (lat == inject_at);
      end while (cnv_cmplt !== 1'b1 && lat < LIMIT);
      nxt = 1'b0;
      checks++;
      if (lat >= LIMIT) begin errors++; $display("FAIL conv_timeout: waited %0d clk, no cnv_cmplt", lat); end
      if (cnv_cmplt === 1'b1) pulses = 1;
      repeat (4) begin @(negedge clk); if (cnv_cmplt === 1'b1) pulses++; end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL rst_ss_n: got %b expected 1", SS_n); end
      checks++; if (SCLK !== 1'b1) begin errors++; $display("FAIL rst_sclk: got %b expected 1", SCLK); end
      checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b expected 0", MOSI); end
      checks++; if (cnv_cmplt !== 1'b0) begin errors++; $display("FAIL rst_cnv: got %b expected 0", cnv_cmplt); end
      checks++; if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h0)
         begin errors++; $display("FAIL rst_results: got %h expected 0", {lft_ld, rght_ld, steer_pot, batt}); end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_round_robin();
      logic [15:0] ec [4] = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};
      int lat, pulses, base;
      adc_val[0] = 12'h111; adc_val[4] = 12'h222; adc_val[5] = 12'h333; adc_val[6] = 12'h444;
      for (int i = 0; i < 4; i++) begin
         base = cmd_q.size();
         run_conv(0, lat, pulses);
         model_conv();
         if (i == 0) ref_lat = lat;
         else begin
            checks++; if (lat != ref_lat) begin errors++; $display("FAIL rr_latency[%0d]: got %0d expected %0d", i, lat, ref_lat); end
         end
         checks++; if (pulses != 1) begin errors++; $display("FAIL rr_pulses[%0d]: got %0d expected 1", i, pulses); end
         checks++;
         if (cmd_q.size() != base + 2 || cmd_q[base] !== ec[i] || cmd_q[base+1] !== ec[i]) begin
            errors++; $display("FAIL rr_cmd[%0d]: got %0d frames first %h expected 2 x %h", i, cmd_q.size() - base,
                               (cmd_q.size() > base) ? cmd_q[base] : 16'hxxxx, ec[i]);
         end
         checks++;
         if ({lft_ld, rght_ld, steer_pot, batt} !== {el, er, es, eb}) begin
            errors++; $display("FAIL rr_results[%0d]: got %h expected %h", i, {lft_ld, rght_ld, steer_pot, batt}, {el, er, es, eb});
         end
      end
   endtask

   task automatic test_single();
      int lat, pulses, base;
      adc_val[0] = 12'h3A5;
      base = cmd_q.size();
      run_conv(0, lat, pulses);
      model_conv();
      checks++; if (cmd_q.size() != base + 2 || cmd_q[base] !== 16'h0000 || cmd_q[base+1] !== 16'h0000)
         begin errors++; $display("FAIL single_cmd: got %0d frames expected 2 x 0000", cmd_q.size() - base); end
      checks++; if (lft_ld !== el) begin errors++; $display("FAIL single_lft: got %h expected %h", lft_ld, el); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulse: got %0d expected 1", pulses); end
      checks++; if (lat != ref_lat) begin errors++; $display("FAIL single_latency: got %0d expected %0d", lat, ref_lat); end
   endtask

   task automatic test_nxt_during_read();
      int lat, pulses, base;
      adc_val[4] = 12'h5A5;
      base = cmd_q.size();
      run_conv(700, lat, pulses);
      model_conv();
      checks++; if (pulses != 1) begin errors++; $display("FAIL ignore_pulses: got %0d expected 1", pulses); end
      checks++; if (cmd_q.size() != base + 2 || cmd_q[base+1] !== 16'h2000)
         begin errors++; $display("FAIL ignore_cmd: got %0d frames expected 2 x 2000", cmd_q.size() - base); end
      checks++; if (rght_ld !== er) begin errors++; $display("FAIL ignore_rght: got %h expected %h", rght_ld, er); end
      repeat (50) @(negedge clk);
      checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL ignore_idle: SS_n got %b expected 1", SS_n); end
      base = cmd_q.size();
      run_conv(0, lat, pulses);
      model_conv();
      checks++; if (cmd_q.size() != base + 2 || cmd_q[base] !== 16'h2800)
         begin errors++; $display("FAIL ignore_advance: got %0d frames expected 2 x 2800", cmd_q.size() - base); end
      checks++; if (steer_pot !== es) begin errors++; $display("FAIL ignore_steer: got %h expected %h", steer_pot, es); end
   endtask

   task automatic test_timing();
      int lat, pulses;
      adc_val[6] = 12'hC3C;
      run_conv(0, lat, pulses);
      model_conv();
      checks++; if (lead != 8) begin errors++; $display("FAIL t_lead: got %0d expected 8", lead); end
      checks++; if (per_min != 32 || per_max != 32) begin errors++; $display("FAIL t_period: got %0d..%0d expected 32", per_min, per_max); end
      checks++; if (half_min != 16 || half_max != 16) begin errors++; $display("FAIL t_fall_to_rise: got %0d..%0d expected 16", half_min, half_max); end
      checks++; if (tail != 16) begin errors++; $display("FAIL t_tail: got %0d expected 16", tail); end
      checks++; if (rise_cnt != 16) begin errors++; $display("FAIL t_bits: got %0d expected 16", rise_cnt); end
      checks++; if (gap < 1) begin errors++; $display("FAIL t_gap: got %0d expected >=1", gap); end
      checks++; if (batt !== eb) begin errors++; $display("FAIL t_batt: got %h expected %h", batt, eb); end
      checks++; if (lat != ref_lat) begin errors++; $display("FAIL t_latency: got %0d expected %0d", lat, ref_lat); end
   endtask

   task automatic test_mid_reset();
      int lat, pulses, base;
      @(negedge clk); nxt = 1'b1;
      @(negedge clk); nxt = 1'b0;
      repeat (300) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (SS_n !== 1'b1 || SCLK !== 1'b1) begin errors++; $display("FAIL mrst_spi: got SS_n %b SCLK %b expected 1 1", SS_n, SCLK); end
      checks++; if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h0)
         begin errors++; $display("FAIL mrst_results: got %h expected 0", {lft_ld, rght_ld, steer_pot, batt}); end
      rst_n = 1'b1;
      model_reset();
      repeat (40) @(negedge clk);
      checks++; if (SS_n !== 1'b1) begin errors++; $display("FAIL mrst_idle: SS_n got %b expected 1", SS_n); end
      base = cmd_q.size();
      run_conv(0, lat, pulses);
      model_conv();
      checks++; if (cmd_q.size() != base + 2 || cmd_q[base+1] !== 16'h0000)
         begin errors++; $display("FAIL mrst_ptr: got %0d frames expected 2 x 0000", cmd_q.size() - base); end
      checks++; if (lft_ld !== el) begin errors++; $display("FAIL mrst_lft: got %h expected %h", lft_ld, el); end
   endtask

`ifdef LD_AVG_EN
   task automatic test_avg();
      int lat, pulses;
      rst_n = 1'b0; repeat (2) @(negedge clk); rst_n = 1'b1;
      model_reset();
      adc_val[0] = 12'h100;
      run_conv(0, lat, pulses); model_conv();
      checks++; if (lft_ld !== 12'h080) begin errors++; $display("FAIL avg_first: got %h expected 080", lft_ld); end
      repeat (3) begin run_conv(0, lat, pulses); model_conv(); end
      adc_val[0] = 12'h201;
      run_conv(0, lat, pulses); model_conv();
      checks++; if (lft_ld !== 12'h180) begin errors++; $display("FAIL avg_second: got %h expected 180", lft_ld); end
   endtask
`endif

   initial begin
      for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;
      test_reset();
      test_round_robin();
      test_single();
      test_nxt_during_read();
      test_timing();
      test_mid_reset();
`ifdef LD_AVG_EN
      test_avg();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
